adsr_envelope_generator: RTL and testbench

- Per-voice linear ADSR envelope stage. Converts a note gate and four 7-bit percent parameters into a 16-bit amplitude level, one update per audio-generation tick (50 kHz).
- Sits downstream of the MIDI/parameter decode and upstream of the voice amplitude multiplier. The mixer uses `active`/`done` for voice allocation.

---
 rtl/adsr_envelope_generator.sv | 141 ++++++++++++++
 tb/tb_adsr_envelope_generator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope_generator.sv
`default_nettype none
// ============================================================================
//  Module   : adsr_envelope_generator
//  Brief    : Per-voice linear ADSR envelope with tick-paced 24-bit accumulator.
//             Optional exponential release tail selected by ADSR_EXP_RELEASE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module adsr_envelope_generator #(
   parameter int PERCENT_WIDTH = 7,
   parameter int LEVEL_WIDTH   = 16,
   parameter int FRAC_WIDTH    = 8,
   parameter int RATE_SHIFT    = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     tick,
   input  logic                     gate,
   input  logic [PERCENT_WIDTH-1:0] attack_rate,
   input  logic [PERCENT_WIDTH-1:0] decay_rate,
   input  logic [PERCENT_WIDTH-1:0] sustain_level,
   input  logic [PERCENT_WIDTH-1:0] release_rate,
   output logic [LEVEL_WIDTH-1:0]   level,
   output logic [2:0]               state,
   output logic                     active,
   output logic                     done
);

   localparam int                     ACC_W      = LEVEL_WIDTH + FRAC_WIDTH;
   localparam logic [ACC_W-1:0]       c_ACC_MAX  = '1;
   localparam logic [PERCENT_WIDTH:0] c_RATE_TOP = {1'b1, {PERCENT_WIDTH{1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   state_t           r_state;
   logic [ACC_W-1:0] r_acc;
   logic             r_gate_q;
   logic             r_active;
   logic             r_done;

   logic             w_rise;
   logic             w_fall;
   logic [ACC_W-1:0] w_inc_a;
   logic [ACC_W-1:0] w_inc_d;
   logic [ACC_W-1:0] w_sus;
   logic [ACC_W-1:0] w_rel_dec;
   logic [ACC_W:0]   w_att_sum;
   logic [ACC_W:0]   w_dec_sub;

   function automatic logic [ACC_W-1:0] f_inc(input logic [PERCENT_WIDTH-1:0] p);
      logic [PERCENT_WIDTH:0] span;
      span = c_RATE_TOP - {1'b0, p};
      return ACC_W'(span) << RATE_SHIFT;
   endfunction

   assign w_rise    = gate & ~r_gate_q;
   assign w_fall    = ~gate & r_gate_q;
   assign w_inc_a   = f_inc(attack_rate);
   assign w_inc_d   = f_inc(decay_rate);
   // Replicating the 7-bit level fills the top 16 bits so 127 lands at 0xFFFF.
   assign w_sus     = {sustain_level, sustain_level,
                       sustain_level[PERCENT_WIDTH-1 -: 2], {FRAC_WIDTH{1'b0}}};
   assign w_att_sum = {1'b0, r_acc} + {1'b0, w_inc_a};
   assign w_dec_sub = {1'b0, r_acc} - {1'b0, w_inc_d};

`ifdef ADSR_EXP_RELEASE_EN
   // The +1 keeps the tail from stalling once the shifted term reaches zero.
   assign w_rel_dec = (r_acc >> (4'd3 + {1'b0, release_rate[PERCENT_WIDTH-1 -: 3]}))
                      + ACC_W'(1);
`else
   assign w_rel_dec = f_inc(release_rate);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_acc    <= '0;
         r_gate_q <= 1'b0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_gate_q <= gate;
         r_done   <= 1'b0;
         if (w_rise) begin
            r_state  <= ST_ATTACK;
            r_active <= 1'b1;
         end else if (w_fall && (r_state == ST_ATTACK || r_state == ST_DECAY ||
                                 r_state == ST_SUSTAIN)) begin
            r_state <= ST_RELEASE;
         end else if (tick) begin
            case (r_state)
               ST_IDLE: r_acc <= '0;
               ST_ATTACK: begin
                  if (w_att_sum >= {1'b0, c_ACC_MAX}) begin
                     r_acc   <= c_ACC_MAX;
                     r_state <= ST_DECAY;
                  end else begin
                     r_acc <= w_att_sum[ACC_W-1:0];
                  end
               end
               ST_DECAY: begin
                  if (w_dec_sub[ACC_W] || (w_dec_sub[ACC_W-1:0] <= w_sus)) begin
                     r_acc   <= w_sus;
                     r_state <= ST_SUSTAIN;
                  end else begin
                     r_acc <= w_dec_sub[ACC_W-1:0];
                  end
               end
               ST_SUSTAIN: r_acc <= w_sus;
               ST_RELEASE: begin
                  if (r_acc <= w_rel_dec) begin
                     r_acc    <= '0;
                     r_state  <= ST_IDLE;
                     r_active <= 1'b0;
                     r_done   <= 1'b1;
                  end else begin
                     r_acc <= r_acc - w_rel_dec;
                  end
               end
               default: begin
                  r_acc    <= '0;
                  r_state  <= ST_IDLE;
                  r_active <= 1'b0;
               end
            endcase
         end
      end
   end

   assign level  = r_acc[ACC_W-1:FRAC_WIDTH];
   assign state  = r_state;
   assign active = r_active;
   assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adsr_envelope_generator
//  Brief    : Vector table, directed corner sequences and random stimulus
//             checked against an arithmetic envelope model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adsr_envelope_generator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tick;
   logic        gate;
   logic [6:0]  attack_rate, decay_rate, sustain_level, release_rate;
   logic [15:0] level;
   logic [2:0]  state;
   logic        active, done;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: accumulator as a plain integer and a phase number
   longint m_acc;
   int     m_ph;
   bit     m_gq, m_done;

   adsr_envelope_generator dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .gate(gate),
      .attack_rate(attack_rate), .decay_rate(decay_rate),
      .sustain_level(sustain_level), .release_rate(release_rate),
      .level(level), .state(state), .active(active), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic longint f_inc(input int p);
      return longint'(128 - p) * 64;
   endfunction

   function automatic longint f_sus(input int s);
      return longint'((s << 9) | (s << 2) | (s >> 5)) << 8;
   endfunction

   task automatic model_reset();
      m_acc = 0; m_ph = 0; m_gq = 0; m_done = 0;
   endtask

   task automatic model_step(input bit t, input bit g);
      longint nxt;
      m_done = 0;
      if (g && !m_gq) m_ph = 1;
      else if (!g && m_gq && m_ph >= 1 && m_ph <= 3) m_ph = 4;
      else if (t) begin
         if (m_ph == 1) begin
            nxt = m_acc + f_inc(attack_rate);
            if (nxt >= 64'hFF_FFFF) begin m_acc = 64'hFF_FFFF; m_ph = 2; end
            else m_acc = nxt;
         end else if (m_ph == 2) begin
            nxt = m_acc - f_inc(decay_rate);
            if (nxt <= f_sus(sustain_level)) begin m_acc = f_sus(sustain_level); m_ph = 3; end
            else m_acc = nxt;
         end else if (m_ph == 3) begin
            m_acc = f_sus(sustain_level);
         end else if (m_ph == 4) begin
            if (m_acc <= f_inc(release_rate)) begin m_acc = 0; m_ph = 0; m_done = 1; end
            else m_acc = m_acc - f_inc(release_rate);
         end
      end
      m_gq = g;
   endtask

   // Drive one cycle from posedge+1, then compare at the following posedge+1
   task automatic cyc(input bit t, input bit g);
      tick = t; gate = g;
      model_step(t, g);
      @(posedge clk); #1;
      chk("level",  level,  m_acc >> 8);
      chk("state",  state,  m_ph);
      chk("active", active, m_ph != 0);
      chk("done",   done,   m_done);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; tick = 1'b0; gate = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      bit          t, g;
      logic [15:0] lvl;
      logic [2:0]  st;
      bit          act, dn;
   } vec_t;

   initial begin
      vec_t vt[8];
      int   cnt, dcnt;
      bit   g_r;

      attack_rate = 0; decay_rate = 0; sustain_level = 64; release_rate = 0;
      do_reset();
      chk("rst_level", level, 0);
      chk("rst_state", state, 0);
      chk("rst_active", active, 0);
      chk("rst_done", done, 0);

      // Fixed vectors with rates 0 (inc 0x2000 -> level step 0x20)
      vt[0] = '{0, 1, 16'h0000, 3'd1, 1, 0};
      vt[1] = '{1, 1, 16'h0020, 3'd1, 1, 0};
      vt[2] = '{1, 1, 16'h0040, 3'd1, 1, 0};
      vt[3] = '{0, 1, 16'h0040, 3'd1, 1, 0};
      vt[4] = '{1, 0, 16'h0040, 3'd4, 1, 0};
      vt[5] = '{1, 0, 16'h0020, 3'd4, 1, 0};
      vt[6] = '{1, 0, 16'h0000, 3'd0, 0, 1};
      vt[7] = '{0, 0, 16'h0000, 3'd0, 0, 0};
      for (int i = 0; i < 8; i++) begin
         tick = vt[i].t; gate = vt[i].g;
         model_step(vt[i].t, vt[i].g);
         @(posedge clk); #1;
         chk("vec_level", level, vt[i].lvl);
         chk("vec_state", state, vt[i].st);
         chk("vec_active", active, vt[i].act);
         chk("vec_done", done, vt[i].dn);
      end

      // Full attack at rate 0
      cyc(0, 1);
      cnt = 0;
      for (int i = 0; i < 3000 && state != 3'd2; i++) begin cyc(1, 1); cnt++; end
      chk("attack_ticks", cnt, 2048);
      chk("attack_peak", level, 16'hFFFF);

      // Decay to sustain 64
      cnt = 0;
      for (int i = 0; i < 2000 && state != 3'd3; i++) begin cyc(1, 1); cnt++; end
      chk("decay_ticks", cnt, 1016);
      chk("sustain_level", level, 16'h8102);

      // Release at rate 0 from 0x810200
      cyc(0, 0);
      chk("release_entry", state, 4);
      cnt = 0; dcnt = 0;
      for (int i = 0; i < 2000 && state != 3'd0; i++) begin
         cyc(1, 0); cnt++; if (done) dcnt++;
      end
      for (int i = 0; i < 3; i++) begin cyc(1, 0); if (done) dcnt++; end
      chk("release_ticks", cnt, 1033);
      chk("done_pulses", dcnt, 1);
      chk("release_end_level", level, 0);

      // Retrigger in RELEASE with a coincident tick
      cyc(0, 1);
      for (int i = 0; i < 512; i++) cyc(1, 1);
      chk("pre_retrig_level", level, 16'h4000);
      cyc(0, 0);
      chk("pre_retrig_state", state, 4);
      cyc(1, 1);
      chk("retrig_state", state, 1);
      chk("retrig_level", level, 16'h4000);
      cyc(1, 1);
      chk("retrig_first_tick", level, 16'h4020);

      // Sustain 127: decay lasts one tick
      sustain_level = 127;
      for (int i = 0; i < 3000 && state != 3'd2; i++) cyc(1, 1);
      chk("s127_in_decay", state, 2);
      cyc(1, 1);
      chk("s127_sustain_state", state, 3);
      chk("s127_sustain_level", level, 16'hFFFF);

      // Sustain 0 tracked live, state held in SUSTAIN
      sustain_level = 0;
      cyc(1, 1);
      cyc(1, 1);
      chk("s0_level", level, 0);
      chk("s0_state", state, 3);
      cyc(0, 0);
      cyc(1, 0);
      chk("s0_release_idle", state, 0);

      // Asynchronous reset mid-attack with no done pulse
      sustain_level = 64;
      cyc(0, 1);
      for (int i = 0; i < 100; i++) cyc(1, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_level", level, 0);
      chk("arst_state", state, 0);
      chk("arst_active", active, 0);
      chk("arst_done", done, 0);
      gate = 1'b0; tick = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (done) dcnt++; end
      chk("arst_no_done", dcnt, 0);
      rst_n = 1'b1;
      model_reset();

      // Randomized run against the model
      g_r = 0;
      for (int i = 0; i < 9000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            attack_rate  = 7'($urandom_range(0, 12));
            decay_rate   = 7'($urandom_range(0, 40));
            release_rate = 7'($urandom_range(0, 40));
         end
         if ($urandom_range(0, 99) == 0) sustain_level = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 1199) == 0) g_r = ~g_r;
         cyc($urandom_range(0, 3) != 0, g_r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
